kds_loader: RTL and testbench



---
 rtl/kds_pkg.sv | 22 ++
 rtl/kds_loader_if.sv | 37 +++
 rtl/kds_row_assembler.sv | 63 ++++++
 rtl/kds_loader.sv | 198 +++++++++++++++++++
 tb/tb_kds_loader.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kds_pkg.sv
// -----------------------------------------------------------------------------
// kds_pkg
// Shared types and constants for the kernel data storage loader.
//   kds_loader_state_t : loader controller states
//   KDS_NB_BLOCKS      : storage blocks per storage instance
//   KDS_FIFO_DEPTH     : FIFO depth, i.e. rows written per block
//   KDS_ROW_WORDS      : kernel words packed into one storage row
// -----------------------------------------------------------------------------
package kds_pkg;

    localparam int KDS_NB_BLOCKS  = 12;
    localparam int KDS_FIFO_DEPTH = 8;
    localparam int KDS_ROW_WORDS  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        CYCLE   = 2'd3
    } kds_loader_state_t;

endpackage : kds_pkg

// File: rtl/kds_loader_if.sv
// -----------------------------------------------------------------------------
// kds_loader_if
// Bundles the kernel word stream and the storage-side row bus.
//   s_data/s_valid/s_ready             : valid/ready kernel word stream
//   v_1/v_2/v_3                        : row words presented to storage
//   le_select                          : one-hot block write strobe
//   cycle_enable/only_readout          : storage rotation controls
// Modports:
//   master : the loader (consumes the stream, drives the storage bus)
//   slave  : the environment (produces the stream, observes the storage bus)
// -----------------------------------------------------------------------------
interface kds_loader_if #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int NB_BLOCKS     = 12
);

    logic [IO_DATA_WIDTH-1:0] s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic [IO_DATA_WIDTH-1:0] v_1;
    logic [IO_DATA_WIDTH-1:0] v_2;
    logic [IO_DATA_WIDTH-1:0] v_3;
    logic [NB_BLOCKS-1:0]     le_select;
    logic                     cycle_enable;
    logic                     only_readout;

    modport master (
        input  s_data, s_valid,
        output s_ready, v_1, v_2, v_3, le_select, cycle_enable, only_readout
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready, v_1, v_2, v_3, le_select, cycle_enable, only_readout
    );

endinterface : kds_loader_if

// File: rtl/kds_row_assembler.sv
// -----------------------------------------------------------------------------
// kds_row_assembler
// Collects three consecutive stream words into v_1, v_2, v_3 (slot 0,1,2).
// Ports:
//   clk, arst_n_in : clock, synchronous active-low reset
//   clear          : return the slot counter to slot 0
//   enable         : accept words (the loader is collecting)
//   s_data/s_valid/s_ready : word stream handshake
//   v_1/v_2/v_3    : assembled row, held until overwritten
//   row_full       : high in the cycle the third word of a row is accepted
// -----------------------------------------------------------------------------
module kds_row_assembler
    import kds_pkg::*;
#(
    parameter int IO_DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [IO_DATA_WIDTH-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [IO_DATA_WIDTH-1:0] v_1,
    output logic [IO_DATA_WIDTH-1:0] v_2,
    output logic [IO_DATA_WIDTH-1:0] v_3,
    output logic                     row_full
);

    localparam logic [1:0] SLOT_LAST = 2'(KDS_ROW_WORDS - 1);

    logic [1:0] slot;
    logic       fire;

    assign s_ready  = enable;
    assign fire     = s_valid && s_ready;
    // Flagged combinationally so the controller can enter WRITE on the very
    // edge that stores the third word.
    assign row_full = fire && (slot == SLOT_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            // NOTE: the row registers are reset because they drive module
            // outputs that must read 0 after reset; they are flops, not a RAM.
            slot <= '0;
            v_1  <= '0;
            v_2  <= '0;
            v_3  <= '0;
        end else if (clear) begin
            slot <= '0;
        end else if (fire) begin
            case (slot)
                2'd0:    v_1 <= s_data;
                2'd1:    v_2 <= s_data;
                default: v_3 <= s_data;
            endcase
            slot <= row_full ? 2'd0 : slot + 2'd1;
        end
    end

endmodule : kds_row_assembler

// File: rtl/kds_loader.sv
// -----------------------------------------------------------------------------
// kds_loader
// Load/rotate controller in front of the kernel data storage. Packs the word
// stream into 3-word rows, writes each row to the current block with a
// one-hot strobe, and sequences rotation runs.
// Ports:
//   clk, arst_n_in  : clock, synchronous active-low reset
//   start           : pulse, begin a full load of all blocks
//   cycle_req       : pulse, start a rotation run
//   cycle_count     : rotation length in cycles (sampled with cycle_req)
//   readout_mode    : run is read-only (sampled with cycle_req)
//   busy            : controller not in IDLE
//   done            : one-cycle pulse after a load or rotation run
//   bus             : stream + storage bus (kds_loader_if.master)
//   err             : sticky request-while-busy flag (KDS_LOADER_ERR_EN only)
// Optional feature macro: KDS_LOADER_ERR_EN
// -----------------------------------------------------------------------------
module kds_loader
    import kds_pkg::*;
#(
    parameter int IO_DATA_WIDTH   = 16,
    parameter int NB_BLOCKS       = KDS_NB_BLOCKS,
    parameter int ROWS_PER_BLOCK  = KDS_FIFO_DEPTH,
    parameter int CYCLE_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       arst_n_in,
    input  logic                       start,
    input  logic                       cycle_req,
    input  logic [CYCLE_CNT_WIDTH-1:0] cycle_count,
    input  logic                       readout_mode,
    output logic                       busy,
    output logic                       done,
    kds_loader_if.master               bus
`ifdef KDS_LOADER_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam int ROW_W = (ROWS_PER_BLOCK > 1) ? $clog2(ROWS_PER_BLOCK) : 1;
    localparam int BLK_W = (NB_BLOCKS > 1) ? $clog2(NB_BLOCKS) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS_PER_BLOCK - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NB_BLOCKS - 1);

    kds_loader_state_t state, next_state;

    logic [ROW_W-1:0]           row_idx;
    logic [BLK_W-1:0]           block_idx;
    logic [CYCLE_CNT_WIDTH-1:0] cycles_left;
    logic                       readout_latched;

    logic                     row_full;
    logic                     asm_ready;
    logic [IO_DATA_WIDTH-1:0] asm_v_1, asm_v_2, asm_v_3;
    logic                     load_last;
    logic                     cycle_go;

    assign load_last = (row_idx == ROW_LAST) && (block_idx == BLK_LAST);
    // start wins over a simultaneous cycle_req in IDLE.
    assign cycle_go  = cycle_req && !start;

    kds_row_assembler #(
        .IO_DATA_WIDTH(IO_DATA_WIDTH)
    ) u_row_assembler (
        .clk      (clk),
        .arst_n_in(arst_n_in),
        .clear    ((state == IDLE) && start),
        .enable   (state == COLLECT),
        .s_data   (bus.s_data),
        .s_valid  (bus.s_valid),
        .s_ready  (asm_ready),
        .v_1      (asm_v_1),
        .v_2      (asm_v_2),
        .v_3      (asm_v_3),
        .row_full (row_full)
    );

    assign bus.s_ready = asm_ready;
    assign bus.v_1     = asm_v_1;
    assign bus.v_2     = asm_v_2;
    assign bus.v_3     = asm_v_3;

    // State register.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so no path through the case leaves next_state
        // unassigned and infers a latch.
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = COLLECT;
                end else if (cycle_req && (cycle_count != '0)) begin
                    next_state = CYCLE;
                end
            end
            COLLECT: begin
                if (row_full) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = load_last ? IDLE : COLLECT;
            end
            CYCLE: begin
                if (cycles_left == CYCLE_CNT_WIDTH'(1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        bus.le_select    = '0;
        bus.cycle_enable = 1'b0;
        bus.only_readout = 1'b0;
        busy             = (state != IDLE);
        case (state)
            WRITE: begin
                bus.le_select = NB_BLOCKS'(1) << block_idx;
            end
            CYCLE: begin
                bus.cycle_enable = 1'b1;
                bus.only_readout = readout_latched;
            end
            default: ;
        endcase
    end

    // Row/block/cycle counters and the done pulse.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            row_idx         <= '0;
            block_idx       <= '0;
            cycles_left     <= '0;
            readout_latched <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cycle_go) begin
                        if (cycle_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            cycles_left     <= cycle_count;
                            readout_latched <= readout_mode;
                        end
                    end
                end
                WRITE: begin
                    if (row_idx == ROW_LAST) begin
                        row_idx <= '0;
                        if (block_idx == BLK_LAST) begin
                            block_idx <= '0;
                            done      <= 1'b1;
                        end else begin
                            block_idx <= block_idx + 1'b1;
                        end
                    end else begin
                        row_idx <= row_idx + 1'b1;
                    end
                end
                CYCLE: begin
                    cycles_left <= cycles_left - 1'b1;
                    if (cycles_left == CYCLE_CNT_WIDTH'(1)) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KDS_LOADER_ERR_EN
    // Sticky: any start/cycle_req while busy is a protocol error.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            err <= 1'b0;
        end else if (busy && (start || cycle_req)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule : kds_loader

// File: tb/tb_kds_loader.sv
// -----------------------------------------------------------------------------
// tb_kds_loader
// Self-checking bench for kds_loader. Expected rows are queued when their
// third word is accepted and compared when the DUT raises le_select.
// Optional feature macro: KDS_LOADER_ERR_EN
// -----------------------------------------------------------------------------
module tb_kds_loader;

    localparam int DW  = 16;
    localparam int NB  = 12;
    localparam int RPB = 8;
    localparam int CW  = 8;

    typedef struct {
        logic [NB-1:0] le;
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
        logic [DW-1:0] v3;
    } row_t;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          start;
    logic          cycle_req;
    logic [CW-1:0] cycle_count;
    logic          readout_mode;
    logic          busy;
    logic          done;
`ifdef KDS_LOADER_ERR_EN
    logic          err;
`endif

    kds_loader_if #(.IO_DATA_WIDTH(DW), .NB_BLOCKS(NB)) bus ();

    kds_loader #(
        .IO_DATA_WIDTH  (DW),
        .NB_BLOCKS      (NB),
        .ROWS_PER_BLOCK (RPB),
        .CYCLE_CNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .arst_n_in   (arst_n_in),
        .start       (start),
        .cycle_req   (cycle_req),
        .cycle_count (cycle_count),
        .readout_mode(readout_mode),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
`ifdef KDS_LOADER_ERR_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_writes = 0;
    int   n_dones  = 0;
    int   exp_row  = 0;
    int   exp_blk  = 0;
    row_t exp_q[$];
    row_t mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (done === 1'b1) n_dones++;
        if (bus.le_select !== '0) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(bus.le_select), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("le_select", 32'(bus.le_select), 32'(mon_e.le));
                check("v_1", 32'(bus.v_1), 32'(mon_e.v1));
                check("v_2", 32'(bus.v_2), 32'(mon_e.v2));
                check("v_3", 32'(bus.v_3), 32'(mon_e.v3));
            end
        end
    end

    task automatic push_row(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        row_t          r;
        logic [NB-1:0] one = NB'(1);
        r.le = one << exp_blk;
        r.v1 = a;
        r.v2 = b;
        r.v3 = c;
        exp_q.push_back(r);
        exp_row++;
        if (exp_row == RPB) begin
            exp_row = 0;
            exp_blk++;
        end
    endtask

    // Offers words base, base+1, ... until n are accepted (bounded).
    task automatic feed(input logic [DW-1:0] base, input int n, input bit toggle);
        int            idx = 0;
        int            cyc = 0;
        logic [DW-1:0] w[3];
        while (idx < n && cyc < 4000) begin
            bus.s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            bus.s_data  = base + DW'(idx);
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) begin
                w[idx % 3] = bus.s_data;
                if ((idx % 3) == 2) push_row(w[0], w[1], w[2]);
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.s_valid = 1'b0;
        check("feed_words_accepted", 32'(idx), 32'(n));
    endtask

    task automatic do_reset();
        arst_n_in    = 1'b0;
        start        = 1'b0;
        cycle_req    = 1'b0;
        cycle_count  = '0;
        readout_mode = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        arst_n_in = 1'b1;
    endtask

    task automatic do_start();
        exp_row = 0;
        exp_blk = 0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        @(negedge clk);
        while (busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
        check({tag, "_v_1"}, 32'(bus.v_1), 32'd0);
        check({tag, "_v_2"}, 32'(bus.v_2), 32'd0);
        check({tag, "_v_3"}, 32'(bus.v_3), 32'd0);
        check({tag, "_le_select"}, 32'(bus.le_select), 32'd0);
        check({tag, "_cycle_enable"}, 32'(bus.cycle_enable), 32'd0);
        check({tag, "_only_readout"}, 32'(bus.only_readout), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, d0, en_cnt, ro_cnt, dn_cnt, last_en, done_at;

        // Reset state.
        do_reset();
        @(negedge clk);
        check_all_zero("rst");
`ifdef KDS_LOADER_ERR_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Full load, s_valid always high.
        w0 = n_writes;
        d0 = n_dones;
        do_start();
        feed(16'h0000, 288, 1'b0);
        wait_idle("load1_idle");
        check("load1_writes", 32'(n_writes - w0), 32'd96);
        check("load1_done", 32'(n_dones - d0), 32'd1);
        check("load1_queue", 32'(exp_q.size()), 32'd0);

        // Full load with s_valid toggling; optional err probe mid-load.
        w0 = n_writes;
        d0 = n_dones;
        do_start();
`ifdef KDS_LOADER_ERR_EN
        fork
            feed(16'h0000, 288, 1'b1);
            begin
                repeat (40) @(posedge clk);
                #1;
                cycle_req   = 1'b1;
                cycle_count = 8'd3;
                @(posedge clk);
                #1;
                cycle_req   = 1'b0;
                cycle_count = '0;
            end
        join
`else
        feed(16'h0000, 288, 1'b1);
`endif
        wait_idle("load2_idle");
        check("load2_writes", 32'(n_writes - w0), 32'd96);
        check("load2_done", 32'(n_dones - d0), 32'd1);
        check("load2_queue", 32'(exp_q.size()), 32'd0);
`ifdef KDS_LOADER_ERR_EN
        check("err_after_load", 32'(err), 32'd1);
`endif

        // Rotation run: 5 cycles, read-only.
        cycle_count  = 8'd5;
        readout_mode = 1'b1;
        cycle_req    = 1'b1;
        @(posedge clk);
        #1;
        cycle_req    = 1'b0;
        readout_mode = 1'b0;
        cycle_count  = '0;
        en_cnt  = 0;
        ro_cnt  = 0;
        dn_cnt  = 0;
        last_en = -1;
        done_at = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.cycle_enable) begin
                en_cnt++;
                last_en = i;
            end
            if (bus.only_readout) ro_cnt++;
            if (done) begin
                dn_cnt++;
                done_at = i;
            end
        end
        check("cycle_enable_len", 32'(en_cnt), 32'd5);
        check("only_readout_len", 32'(ro_cnt), 32'd5);
        check("cycle_done_count", 32'(dn_cnt), 32'd1);
        check("cycle_done_timing", 32'(done_at), 32'(last_en + 1));
        @(posedge clk);
        #1;

        // Rotation request of length 0: immediate done, stays idle.
        cycle_count = '0;
        cycle_req   = 1'b1;
        @(posedge clk);
        #1;
        cycle_req = 1'b0;
        @(negedge clk);
        check("zero_cycle_done", 32'(done), 32'd1);
        check("zero_cycle_busy", 32'(busy), 32'd0);
        check("zero_cycle_ce", 32'(bus.cycle_enable), 32'd0);
        @(posedge clk);
        #1;

        // start and cycle_req together: load wins.
        exp_row     = 0;
        exp_blk     = 0;
        start       = 1'b1;
        cycle_req   = 1'b1;
        cycle_count = 8'd5;
        @(posedge clk);
        #1;
        start       = 1'b0;
        cycle_req   = 1'b0;
        cycle_count = '0;
        @(negedge clk);
        check("prio_s_ready", 32'(bus.s_ready), 32'd1);
        check("prio_cycle_enable", 32'(bus.cycle_enable), 32'd0);
        @(posedge clk);
        #1;

        // Two words of row 0, then reset mid-row.
        feed(16'hA000, 2, 1'b0);
`ifdef KDS_LOADER_ERR_EN
        check("err_sticky", 32'(err), 32'd1);
`endif
        arst_n_in = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("midrst");
`ifdef KDS_LOADER_ERR_EN
        check("midrst_err", 32'(err), 32'd0);
`endif
        @(posedge clk);
        #1;
        arst_n_in = 1'b1;

        // Restart: the first row must carry only the new words.
        w0 = n_writes;
        do_start();
        feed(16'hB000, 3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("restart_writes", 32'(n_writes - w0), 32'd1);
        check("restart_queue", 32'(exp_q.size()), 32'd0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_kds_loader
